// File: rtl/if_stage_if.sv
// Fetch-stage bus: hazard/branch controls in, instruction memory port and IF/ID outputs.
// The master modport is the fetch stage; the slave modport is the surrounding pipeline/memory.
interface if_stage_if;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] imem_addr;
    logic [31:0] imem_data;
    logic [31:0] pc;
    logic [31:0] if_instr;
    logic [31:0] id_instr;
    logic [31:0] id_pc4;
    logic        id_valid;
    logic [31:0] fetch_cnt;
    logic [31:0] flush_cnt;

    modport master (
        input  stall, branch_taken, branch_target, imem_data,
        output imem_addr, pc, if_instr, id_instr, id_pc4, id_valid, fetch_cnt, flush_cnt
    );

    modport slave (
        output stall, branch_taken, branch_target, imem_data,
        input  imem_addr, pc, if_instr, id_instr, id_pc4, id_valid, fetch_cnt, flush_cnt
    );
endinterface

// File: rtl/if_stage.sv
// Instruction fetch: program counter, instruction memory addressing and the IF/ID register.
//   mode  | meaning
//   RESET | pc at PC_RESET, bubble in IF/ID, counters cleared
//   RUN   | pc advances by 4, fetched word captured into IF/ID
//   STALL | everything holds; a pending branch is re-presented later
//   FLUSH | pc redirected, wrong-path word replaced by a bubble
module if_stage #(
    parameter logic [31:0] PC_RESET  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic clk,
    input  logic rst,
    if_stage_if.master bus
);
    logic [31:0] pc_q;
    logic [31:0] pc_plus4;
    logic [31:0] id_instr_q;
    logic [31:0] id_pc4_q;
    logic        id_valid_q;
    logic [31:0] fetch_cnt_q;
    logic [31:0] flush_cnt_q;
    logic        unused_target_lsbs;

    assign pc_plus4           = pc_q + 32'd4;
    assign unused_target_lsbs = ^bus.branch_target[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= {PC_RESET[31:2], 2'b00};
            id_instr_q  <= NOP_INSTR;
            id_pc4_q    <= 32'h0000_0000;
            id_valid_q  <= 1'b0;
            fetch_cnt_q <= 32'h0000_0000;
            flush_cnt_q <= 32'h0000_0000;
        end else if (!bus.stall) begin
            if (bus.branch_taken) begin
                // id_pc4 deliberately holds; only the instruction word is squashed.
                pc_q        <= {bus.branch_target[31:2], 2'b00};
                id_instr_q  <= NOP_INSTR;
                id_valid_q  <= 1'b0;
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end else begin
                pc_q        <= pc_plus4;
                id_instr_q  <= bus.imem_data;
                id_pc4_q    <= pc_plus4;
                id_valid_q  <= 1'b1;
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            end
        end
    end

    assign bus.imem_addr = pc_q;
    assign bus.pc        = pc_q;
    assign bus.if_instr  = bus.imem_data;
    assign bus.id_instr  = id_instr_q;
    assign bus.id_pc4    = id_pc4_q;
    assign bus.id_valid  = id_valid_q;
    assign bus.fetch_cnt = fetch_cnt_q;
    assign bus.flush_cnt = flush_cnt_q;
endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: reference model pushes expected IF/ID state per edge,
// checked after the edge, plus fixed-value checks and a second instance for PC wrap.
module tb_if_stage;
    typedef struct {
        logic [31:0] pc;
        logic [31:0] id_instr;
        logic [31:0] id_pc4;
        logic        id_valid;
        logic [31:0] fetch_cnt;
        logic [31:0] flush_cnt;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic rst_w;
    int   total = 0;
    int   bad   = 0;
    exp_t sb[$];

    logic [31:0] m_pc, m_id_instr, m_id_pc4, m_fetch, m_flush;
    logic        m_valid;

    always #5 clk = ~clk;

    if_stage_if bus ();
    if_stage_if wbus ();

    if_stage #(.PC_RESET(32'h0000_0000), .NOP_INSTR(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .bus(bus.master)
    );
    if_stage #(.PC_RESET(32'hFFFF_FFF8), .NOP_INSTR(32'h0000_0000)) dut_w (
        .clk(clk), .rst(rst_w), .bus(wbus.master)
    );

    function automatic logic [31:0] imem_word(input logic [31:0] addr);
        return 32'h1000_0000 + (addr >> 2);
    endfunction

    assign bus.imem_data  = imem_word(bus.imem_addr);
    assign wbus.imem_data = imem_word(wbus.imem_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, predict the post-edge state, then check it after the edge.
    task automatic step(input logic r, input logic s, input logic b, input logic [31:0] tgt);
        exp_t e;
        exp_t got;
        rst               = r;
        bus.stall         = s;
        bus.branch_taken  = b;
        bus.branch_target = tgt;
        if (r) begin
            m_pc = 32'h0; m_id_instr = 32'h0; m_id_pc4 = 32'h0;
            m_valid = 1'b0; m_fetch = 32'h0; m_flush = 32'h0;
        end else if (!s) begin
            if (b) begin
                m_pc = {tgt[31:2], 2'b00}; m_id_instr = 32'h0; m_valid = 1'b0;
                m_flush = m_flush + 1;
            end else begin
                m_id_instr = imem_word(m_pc); m_id_pc4 = m_pc + 4; m_valid = 1'b1;
                m_pc = m_pc + 4; m_fetch = m_fetch + 1;
            end
        end
        e.pc = m_pc; e.id_instr = m_id_instr; e.id_pc4 = m_id_pc4;
        e.id_valid = m_valid; e.fetch_cnt = m_fetch; e.flush_cnt = m_flush;
        sb.push_back(e);
        @(posedge clk);
        #1;
        got = sb.pop_front();
        chk("sb_pc",        bus.pc,        got.pc);
        chk("sb_id_instr",  bus.id_instr,  got.id_instr);
        chk("sb_id_pc4",    bus.id_pc4,    got.id_pc4);
        chk("sb_id_valid",  {31'b0, bus.id_valid}, {31'b0, got.id_valid});
        chk("sb_fetch_cnt", bus.fetch_cnt, got.fetch_cnt);
        chk("sb_flush_cnt", bus.flush_cnt, got.flush_cnt);
        chk("imem_addr",    bus.imem_addr, got.pc);
        chk("if_instr",     bus.if_instr,  imem_word(got.pc));
    endtask

    initial begin
        rst = 1'b1; rst_w = 1'b1;
        bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.branch_target = 32'h0;
        wbus.stall = 1'b0; wbus.branch_taken = 1'b0; wbus.branch_target = 32'h0;
        m_pc = 0; m_id_instr = 0; m_id_pc4 = 0; m_valid = 0; m_fetch = 0; m_flush = 0;

        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        chk("reset_pc", bus.pc, 32'h0);
        chk("reset_valid", {31'b0, bus.id_valid}, 32'h0);

        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("first_pc", bus.pc, 32'h4);
        chk("first_instr", bus.id_instr, 32'h1000_0000);
        chk("first_pc4", bus.id_pc4, 32'h4);
        chk("first_valid", {31'b0, bus.id_valid}, 32'h1);

        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("pre_stall_pc", bus.pc, 32'h10);

        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 1'b0, 32'h0);
            chk("stall_pc", bus.pc, 32'h10);
            chk("stall_instr", bus.id_instr, 32'h1000_0003);
            chk("stall_fetch", bus.fetch_cnt, 32'd4);
        end
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("resume_pc", bus.pc, 32'h14);
        chk("resume_instr", bus.id_instr, 32'h1000_0004);
        chk("fetch_cnt5", bus.fetch_cnt, 32'd5);

        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("pre_branch_pc", bus.pc, 32'h20);

        step(1'b0, 1'b0, 1'b1, 32'h0000_0103);
        chk("br_pc", bus.pc, 32'h100);
        chk("br_valid", {31'b0, bus.id_valid}, 32'h0);
        chk("br_instr", bus.id_instr, 32'h0);
        chk("br_flush", bus.flush_cnt, 32'd1);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("br_tgt_instr", bus.id_instr, 32'h1000_0040);
        chk("br_tgt_pc4", bus.id_pc4, 32'h104);

        step(1'b0, 1'b1, 1'b1, 32'h0000_0200);
        chk("stbr_pc", bus.pc, 32'h104);
        chk("stbr_flush", bus.flush_cnt, 32'd1);
        step(1'b0, 1'b0, 1'b1, 32'h0000_0200);
        chk("stbr_redirect", bus.pc, 32'h200);
        chk("stbr_flush2", bus.flush_cnt, 32'd2);

        step(1'b0, 1'b0, 1'b1, 32'h0000_0040);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b1, 1'b1, 32'h0000_0080);
        chk("mid_rst_pc", bus.pc, 32'h0);
        chk("mid_rst_valid", {31'b0, bus.id_valid}, 32'h0);
        chk("mid_rst_instr", bus.id_instr, 32'h0);
        chk("mid_rst_fetch", bus.fetch_cnt, 32'h0);
        chk("mid_rst_flush", bus.flush_cnt, 32'h0);
        step(1'b0, 1'b0, 1'b0, 32'h0);
        chk("post_rst_instr", bus.id_instr, 32'h1000_0000);

        chk("wrap_pc0", wbus.pc, 32'hFFFF_FFF8);
        rst_w = 1'b0;
        @(posedge clk); #1;
        chk("wrap_pc1", wbus.pc, 32'hFFFF_FFFC);
        chk("wrap_pc4_1", wbus.id_pc4, 32'hFFFF_FFFC);
        @(posedge clk); #1;
        chk("wrap_pc2", wbus.pc, 32'h0000_0000);
        chk("wrap_pc4_2", wbus.id_pc4, 32'h0000_0000);
        chk("wrap_instr", wbus.id_instr, 32'h4FFF_FFFF);
        @(posedge clk); #1;
        chk("wrap_pc3", wbus.pc, 32'h0000_0004);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
